snd_dma_seq: RTL and testbench

//  Parametrised successor of the MCU sound-DMA frame counter. It sequences N independent
//  DMA sound channels, each with a double-buffered start/end frame, a one-shot or repeat

---
 rtl/snd_dma_seq.sv | 197 +++++++++++++++++++
 tb/tb_snd_dma_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/snd_dma_seq.sv
// snd_dma_seq: N-channel sound-DMA frame sequencer, round-robin slot grant.
// Optional SND_FRAME_CNT_EN: per-channel completed-frame counter, diag read.
module snd_dma_seq #(
   parameter int CHANNELS = 2,
   parameter int AW       = 21,
   localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk32,
   input  logic                res,
   input  logic                reg_wr,
   input  logic [CHW-1:0]      reg_ch,
   input  logic [1:0]          reg_sel,
   input  logic [AW-1:0]       reg_din,
   output logic [AW-1:0]       reg_dout,
   input  logic [CHANNELS-1:0] sreq,
   input  logic                slot_en,
   output logic                dma_valid,
   output logic [AW-1:0]       dma_addr,
   output logic [CHW-1:0]      dma_ch,
   output logic [CHANNELS-1:0] sint,
   output logic [CHANNELS-1:0] sndon
);

   typedef logic [CHANNELS-1:0][AW-1:0] addr_arr_t;

   logic [CHANNELS-1:0] active_q, active_d, rpt_q, rpt_d;
   logic [CHANNELS-1:0] pend_q, pend_d, sint_q, sint_d;
   addr_arr_t           sstart_q, sstart_d, send_q, send_d;
   addr_arr_t           lend_q, lend_d, cnt_q, cnt_d;
   logic [CHW-1:0]      rr_q, rr_d, dch_q, dch_d;
   logic                dv_q, dv_d;
   logic [AW-1:0]       daddr_q, daddr_d;
   logic [CHANNELS-1:0] kill, elig, gnt;
   logic                found;
   logic [CHW-1:0]      gidx;
`ifdef SND_FRAME_CNT_EN
   logic [CHANNELS-1:0][7:0] fcnt_q, fcnt_d;
   logic                     diag_q, diag_d;
`endif

   function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base,
                                             input int off);
      int s;
      s = int'(base) + off;
      if (s >= CHANNELS) s = s - CHANNELS;
      return CHW'(s);
   endfunction

   // register writes, frame start/end, arbitration and next-state
   always_comb begin
      active_d = active_q;
      rpt_d    = rpt_q;
      sstart_d = sstart_q;
      send_d   = send_q;
      lend_d   = lend_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      sint_d   = '0;
      dv_d     = 1'b0;
      daddr_d  = '0;
      dch_d    = '0;
      kill     = '0;
      found    = 1'b0;
      gidx     = '0;
      gnt      = '0;
`ifdef SND_FRAME_CNT_EN
      fcnt_d   = fcnt_q;
      diag_d   = diag_q;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
         if (reg_wr && reg_ch == CHW'(c)) begin
            unique case (reg_sel)
               2'd0: begin
                  rpt_d[c] = reg_din[1];
`ifdef SND_FRAME_CNT_EN
                  diag_d = reg_din[AW-1];
`endif
                  if (!reg_din[0]) begin
                     active_d[c] = 1'b0;
                     kill[c]     = 1'b1;
                  end else if (!active_q[c]) begin
                     cnt_d[c]  = sstart_q[c];
                     lend_d[c] = send_q[c];
`ifdef SND_FRAME_CNT_EN
                     fcnt_d[c] = '0;
`endif
                     if (sstart_q[c] == send_q[c]) sint_d[c] = 1'b1;
                     else active_d[c] = 1'b1;
                  end
               end
               2'd1: sstart_d[c] = reg_din;
               2'd2: send_d[c]   = reg_din;
               default: ;
            endcase
         end
      end
      elig = pend_q & ~kill;
      if (slot_en) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!found && elig[rr_idx(rr_q, i)]) begin
               found = 1'b1;
               gidx  = rr_idx(rr_q, i);
            end
         end
      end
      if (found) begin
         gnt        = CHANNELS'(1) << gidx;
         dv_d       = 1'b1;
         daddr_d    = cnt_q[gidx];
         dch_d      = gidx;
         rr_d       = rr_idx(gidx, 1);
         cnt_d[gidx] = cnt_q[gidx] + AW'(1);
         if (cnt_q[gidx] + AW'(1) == lend_q[gidx]) begin
            sint_d[gidx] = 1'b1;
            if (rpt_q[gidx] && (sstart_q[gidx] != send_q[gidx])) begin
               cnt_d[gidx]  = sstart_q[gidx];
               lend_d[gidx] = send_q[gidx];
            end else begin
               active_d[gidx] = 1'b0;
            end
         end
      end
      pend_d = ((pend_q & ~gnt) | (sreq & active_q)) & active_d;
`ifdef SND_FRAME_CNT_EN
      for (int c = 0; c < CHANNELS; c++) begin
         if (sint_d[c]) fcnt_d[c] = fcnt_d[c] + 8'd1;
      end
`endif
   end

   // state registers with synchronous reset
   always_ff @(posedge clk32) begin
      if (res) begin
         active_q <= '0;
         rpt_q    <= '0;
         pend_q   <= '0;
         sint_q   <= '0;
         sstart_q <= '0;
         send_q   <= '0;
         lend_q   <= '0;
         cnt_q    <= '0;
         rr_q     <= '0;
         dch_q    <= '0;
         dv_q     <= 1'b0;
         daddr_q  <= '0;
`ifdef SND_FRAME_CNT_EN
         fcnt_q   <= '0;
         diag_q   <= 1'b0;
`endif
      end else begin
         active_q <= active_d;
         rpt_q    <= rpt_d;
         pend_q   <= pend_d;
         sint_q   <= sint_d;
         sstart_q <= sstart_d;
         send_q   <= send_d;
         lend_q   <= lend_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         dch_q    <= dch_d;
         dv_q     <= dv_d;
         daddr_q  <= daddr_d;
`ifdef SND_FRAME_CNT_EN
         fcnt_q   <= fcnt_d;
         diag_q   <= diag_d;
`endif
      end
   end

   // combinational register read-back
   always_comb begin
      reg_dout = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (reg_ch == CHW'(c)) begin
            unique case (reg_sel)
               2'd0: reg_dout = AW'({rpt_q[c], active_q[c]});
               2'd1: reg_dout = sstart_q[c];
               2'd2: reg_dout = send_q[c];
               default: begin
`ifdef SND_FRAME_CNT_EN
                  reg_dout = diag_q ? AW'(fcnt_q[c]) : cnt_q[c];
`else
                  reg_dout = cnt_q[c];
`endif
               end
            endcase
         end
      end
   end

   assign dma_valid = dv_q;
   assign dma_addr  = daddr_q;
   assign dma_ch    = dch_q;
   assign sint      = sint_q;
   assign sndon     = active_q;

endmodule

// File: tb/tb_snd_dma_seq.sv
// tb_snd_dma_seq: vector table plus hand sequences for snd_dma_seq.
// Frame-counter sequence follows SND_FRAME_CNT_EN when defined.
module tb_snd_dma_seq;
   localparam int AW = 21;

   logic          clk32 = 1'b0;
   logic          res, reg_wr, slot_en, dma_valid;
   logic [0:0]    reg_ch, dma_ch;
   logic [1:0]    reg_sel, sreq, sint, sndon;
   logic [AW-1:0] reg_din, reg_dout, dma_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk32 = ~clk32;

   snd_dma_seq #(.CHANNELS(2), .AW(AW)) dut (
      .clk32(clk32), .res(res), .reg_wr(reg_wr), .reg_ch(reg_ch),
      .reg_sel(reg_sel), .reg_din(reg_din), .reg_dout(reg_dout),
      .sreq(sreq), .slot_en(slot_en), .dma_valid(dma_valid),
      .dma_addr(dma_addr), .dma_ch(dma_ch), .sint(sint), .sndon(sndon)
   );

   typedef struct {
      bit            res;
      bit            wr;
      logic          ch;
      logic [1:0]    sel;
      logic [AW-1:0] din;
      logic [1:0]    sreq;
      bit            slot;
      bit            dv;
      logic [AW-1:0] addr;
      logic          och;
      logic [1:0]    sint;
      logic [1:0]    sndon;
      bit            rd;
      logic          rch;
      logic [1:0]    rsel;
      logic [AW-1:0] rexp;
   } vec_t;

   vec_t vq[$];

   task automatic g(input int r, w, ch, sel, input logic [AW-1:0] din,
                    input int sq, sl, dv, input logic [AW-1:0] addr,
                    input int och, si, on);
      vec_t t;
      t.res = r[0]; t.wr = w[0]; t.ch = ch[0]; t.sel = 2'(sel);
      t.din = din; t.sreq = 2'(sq); t.slot = sl[0]; t.dv = dv[0];
      t.addr = addr; t.och = och[0]; t.sint = 2'(si); t.sndon = 2'(on);
      t.rd = 1'b0; t.rch = 1'b0; t.rsel = 2'd0; t.rexp = '0;
      vq.push_back(t);
   endtask

   task automatic rs();
      g(1, 0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic w(input int ch, sel, input logic [AW-1:0] din,
                    input int si, on);
      g(0, 1, ch, sel, din, 0, 0, 0, '0, 0, si, on);
   endtask

   task automatic s(input int sq, sl, dv, input logic [AW-1:0] addr,
                    input int och, si, on);
      g(0, 0, 0, 0, '0, sq, sl, dv, addr, och, si, on);
   endtask

   task automatic rd(input int ch, sel, input logic [AW-1:0] ex);
      vec_t t;
      t = vq.pop_back();
      t.rd = 1'b1; t.rch = ch[0]; t.rsel = 2'(sel); t.rexp = ex;
      vq.push_back(t);
   endtask

   task automatic pin(input bit r, wr, input logic ch,
                      input logic [1:0] sel, input logic [AW-1:0] din,
                      input logic [1:0] sq, input bit sl);
      @(negedge clk32);
      res = r; reg_wr = wr; reg_ch = ch; reg_sel = sel;
      reg_din = din; sreq = sq; slot_en = sl;
      @(posedge clk32);
      #1;
   endtask

   task automatic rchk(input string nm, input logic ch,
                       input logic [1:0] sel, input logic [AW-1:0] ex);
      reg_wr = 1'b0; reg_ch = ch; reg_sel = sel;
      #1;
      checks++;
      if (reg_dout !== ex) begin
         failures++;
         $display("FAIL %s ch%0d sel%0d reg_dout got=%h exp=%h",
                  nm, ch, sel, reg_dout, ex);
      end
   endtask

   initial begin
      logic [AW+5:0] got, exp;
      vec_t t;
      res = 1'b1; reg_wr = 1'b0; reg_ch = '0; reg_sel = '0;
      reg_din = '0; sreq = '0; slot_en = 1'b0;

      // 1: one-shot frame
      rs();
      w(0, 1, 'h1000, 0, 0);
      w(0, 2, 'h1003, 0, 0); rd(0, 2, 'h1003);
      w(0, 0, 1, 0, 1); rd(0, 0, 1);
      s(1, 1, 0, '0, 0, 0, 1);
      s(1, 1, 1, 'h1000, 0, 0, 1);
      s(1, 1, 1, 'h1001, 0, 0, 1);
      s(1, 1, 1, 'h1002, 0, 1, 0); rd(0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0); rd(0, 3, 'h1003);
      // 2: repeat with mid-frame shadow end write, then disable
      rs();
      w(0, 1, 'h1000, 0, 0);
      w(0, 2, 'h1003, 0, 0);
      w(0, 0, 3, 0, 1); rd(0, 0, 3);
      s(1, 1, 0, '0, 0, 0, 1);
      s(1, 1, 1, 'h1000, 0, 0, 1);
      g(0, 1, 0, 2, 'h1005, 1, 1, 1, 'h1001, 0, 0, 1); rd(0, 2, 'h1005);
      s(1, 1, 1, 'h1002, 0, 1, 1);
      s(1, 1, 1, 'h1000, 0, 0, 1);
      s(1, 1, 1, 'h1001, 0, 0, 1);
      s(1, 1, 1, 'h1002, 0, 0, 1);
      s(1, 1, 1, 'h1003, 0, 0, 1);
      s(1, 1, 1, 'h1004, 0, 1, 1);
      s(1, 1, 1, 'h1000, 0, 0, 1);
      g(0, 1, 0, 0, '0, 1, 1, 0, '0, 0, 0, 0); rd(0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0);
      // 3: round robin over two channels
      rs();
      w(0, 1, 'h100, 0, 0);
      w(0, 2, 'h200, 0, 0);
      w(1, 1, 'h300, 0, 0);
      w(1, 2, 'h400, 0, 0);
      w(0, 0, 1, 0, 1);
      w(1, 0, 1, 0, 3);
      s(3, 1, 0, '0, 0, 0, 3);
      s(3, 1, 1, 'h100, 0, 0, 3);
      s(3, 1, 1, 'h300, 1, 0, 3);
      s(3, 1, 1, 'h101, 0, 0, 3);
      s(3, 1, 1, 'h301, 1, 0, 3);
      s(3, 0, 0, '0, 0, 0, 3);
      s(3, 1, 1, 'h102, 0, 0, 3);
      // 4: empty frame with repeat, sel3 write ignored
      rs();
      w(0, 3, 'h777, 0, 0); rd(0, 3, 0);
      w(0, 1, 'h2000, 0, 0);
      w(0, 2, 'h2000, 0, 0);
      w(0, 0, 3, 1, 0); rd(0, 0, 2);
      s(1, 1, 0, '0, 0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0);
      // 5a: address wrap
      rs();
      w(0, 1, 'h1FFFFE, 0, 0);
      w(0, 2, 1, 0, 0);
      w(0, 0, 1, 0, 1);
      s(1, 1, 0, '0, 0, 0, 1);
      s(1, 1, 1, 'h1FFFFE, 0, 0, 1);
      s(1, 1, 1, 'h1FFFFF, 0, 0, 1);
      s(1, 1, 1, 'h0, 0, 1, 0); rd(0, 3, 1);
      s(1, 1, 0, '0, 0, 0, 0);
      // 5b: disable mid-frame
      rs();
      w(0, 1, 'h1FFFFE, 0, 0);
      w(0, 2, 1, 0, 0);
      w(0, 0, 1, 0, 1);
      s(1, 1, 0, '0, 0, 0, 1);
      s(1, 1, 1, 'h1FFFFE, 0, 0, 1);
      g(0, 1, 0, 0, '0, 1, 1, 0, '0, 0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0);
      // reset aborts a pending frame-ending grant
      rs();
      w(0, 1, 'h40, 0, 0);
      w(0, 2, 'h41, 0, 0);
      w(0, 0, 1, 0, 1);
      s(1, 1, 0, '0, 0, 0, 1);
      g(1, 0, 0, 0, '0, 1, 1, 0, '0, 0, 0, 0);
      s(1, 1, 0, '0, 0, 0, 0);

      pin(1, 0, 0, 0, '0, 0, 0);
      pin(1, 0, 0, 0, '0, 0, 0);
      pin(0, 0, 0, 0, '0, 0, 0);
      checks++;
      if ({dma_valid, sint, sndon} !== 5'b0) begin
         failures++;
         $display("FAIL reset_out got=%b exp=0", {dma_valid, sint, sndon});
      end
      for (int k = 0; k < 4; k++) rchk("reset_rd", 1'b0, 2'(k), '0);
      rchk("reset_rd", 1'b1, 2'd3, '0);

      for (int k = 0; k < vq.size(); k++) begin
         t = vq[k];
         pin(t.res, t.wr, t.ch, t.sel, t.din, t.sreq, t.slot);
         got = {dma_valid, (t.dv ? dma_addr : '0),
                (t.dv ? dma_ch[0] : 1'b0), sint, sndon};
         exp = {t.dv, t.addr, t.och, t.sint, t.sndon};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL row%0d {dv,addr,ch,sint,sndon} got=%h exp=%h",
                     k, got, exp);
         end
         if (t.rd) rchk($sformatf("row%0d_rd", k), t.rch, t.rsel, t.rexp);
      end

      // 6: completed-frame counter over single-word repeat frames
      pin(1, 0, 0, 0, '0, 0, 0);
      pin(0, 1, 0, 1, 'h10, 0, 0);
      pin(0, 1, 0, 2, 'h11, 0, 0);
      pin(0, 1, 0, 0, 'h100003, 0, 0);
      pin(0, 0, 0, 0, '0, 1, 0);
      for (int k = 0; k < 3; k++) pin(0, 0, 0, 0, '0, 1, 1);
      pin(0, 0, 0, 0, '0, 1, 0);
`ifdef SND_FRAME_CNT_EN
      rchk("fcnt3", 1'b0, 2'd3, 'd3);
`else
      rchk("nodiag3", 1'b0, 2'd3, 'h10);
`endif
      for (int k = 0; k < 253; k++) pin(0, 0, 0, 0, '0, 1, 1);
      pin(0, 0, 0, 0, '0, 1, 0);
`ifdef SND_FRAME_CNT_EN
      rchk("fcnt256", 1'b0, 2'd3, 'd0);
`else
      rchk("nodiag256", 1'b0, 2'd3, 'h10);
`endif
      rchk("rpt_active", 1'b0, 2'd0, 'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
